// File: rtl/mem_bus_arbiter.sv
// Arbitrates the ibus (fetch) and dbus (load/store) masters onto one single-ported memory port.
// Latency: request seen at T -> O_mem_req at T+1, earliest ready at T+2, next grant decision at T+3.
// Backpressure: masters hold requests until their ready pulse; memory acks or the watchdog ends a transaction.
// Optional feature macro: ARB_ROUND_ROBIN_EN (alternate ties between masters; default dbus wins ties).
module mem_bus_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                MASK_W   = 4,
    parameter int                TIMEOUT  = 16,
    parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_ibus_req,
    input  logic [ADDR_W-1:0] I_ibus_addr,
    output logic [DATA_W-1:0] O_ibus_data,
    output logic              O_ibus_ready,
    input  logic              I_dbus_req,
    input  logic              I_dbus_we,
    input  logic [ADDR_W-1:0] I_dbus_addr,
    input  logic [DATA_W-1:0] I_dbus_data,
    input  logic [MASK_W-1:0] I_dbus_mask,
    output logic [DATA_W-1:0] O_dbus_data,
    output logic              O_dbus_ready,
    output logic              O_mem_req,
    output logic              O_mem_we,
    output logic [ADDR_W-1:0] O_mem_addr,
    output logic [DATA_W-1:0] O_mem_data,
    output logic [MASK_W-1:0] O_mem_mask,
    input  logic              I_mem_ack,
    input  logic [DATA_W-1:0] I_mem_data,
    output logic              O_bus_err
);

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WDOG_MAX = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic             r_owner_dbus;
    logic [CNT_W-1:0] r_wdog;

    logic w_grant_dbus;
    logic w_start;
    logic w_ack;
    logic w_timeout;
    logic w_done;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_dbus;

    // Remember which master won the last grant so the other one wins the next tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_dbus <= 1'b0;
        end else if (w_start) begin
            r_last_dbus <= w_grant_dbus;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: requests only sampled in IDLE; BUSY ends on ack or watchdog expiry.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_start) w_next_state = ST_BUSY;
            ST_BUSY: if (w_done)  w_next_state = ST_RESP;
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Output-side decode: winner selection and the BUSY completion conditions.
    always_comb begin
        w_grant_dbus = 1'b0;
        w_start      = 1'b0;
        w_ack        = 1'b0;
        w_timeout    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        w_grant_dbus = I_dbus_req & (~I_ibus_req | ~r_last_dbus);
`else
        w_grant_dbus = I_dbus_req;
`endif
        w_start   = (r_state == ST_IDLE) & (I_ibus_req | I_dbus_req);
        w_ack     = (r_state == ST_BUSY) & I_mem_ack;
        w_timeout = (r_state == ST_BUSY) & ~I_mem_ack & (r_wdog == WDOG_MAX);
        w_done    = w_ack | w_timeout;
    end

    // Registered outputs: latch the memory request on grant, route the response back on completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            O_mem_req    <= 1'b0;
            O_mem_we     <= 1'b0;
            O_mem_addr   <= '0;
            O_mem_data   <= '0;
            O_mem_mask   <= '0;
            O_ibus_data  <= '0;
            O_ibus_ready <= 1'b0;
            O_dbus_data  <= '0;
            O_dbus_ready <= 1'b0;
            O_bus_err    <= 1'b0;
            r_owner_dbus <= 1'b0;
            r_wdog       <= '0;
        end else begin
            O_ibus_ready <= 1'b0;
            O_dbus_ready <= 1'b0;
            O_bus_err    <= 1'b0;
            if (w_start) begin
                O_mem_req    <= 1'b1;
                r_owner_dbus <= w_grant_dbus;
                r_wdog       <= '0;
                if (w_grant_dbus) begin
                    O_mem_we   <= I_dbus_we;
                    O_mem_addr <= I_dbus_addr;
                    O_mem_data <= I_dbus_data;
                    O_mem_mask <= I_dbus_mask;
                end else begin
                    // Fetch is read-only: never write, never enable bytes.
                    O_mem_we   <= 1'b0;
                    O_mem_addr <= I_ibus_addr;
                    O_mem_data <= '0;
                    O_mem_mask <= '0;
                end
            end
            if (r_state == ST_BUSY) begin
                if (w_done) begin
                    O_mem_req <= 1'b0;
                    O_bus_err <= w_timeout;
                    if (r_owner_dbus) begin
                        O_dbus_ready <= 1'b1;
                        O_dbus_data  <= w_ack ? I_mem_data : ERR_DATA;
                    end else begin
                        O_ibus_ready <= 1'b1;
                        O_ibus_data  <= w_ack ? I_mem_data : ERR_DATA;
                    end
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a response scoreboard.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there or on the falling edge.
// Build with ARB_ROUND_ROBIN_EN defined to check the alternating tie order instead of fixed priority.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_ibus_req;
    logic [31:0] I_ibus_addr;
    logic [31:0] O_ibus_data;
    logic        O_ibus_ready;
    logic        I_dbus_req;
    logic        I_dbus_we;
    logic [31:0] I_dbus_addr;
    logic [31:0] I_dbus_data;
    logic [3:0]  I_dbus_mask;
    logic [31:0] O_dbus_data;
    logic        O_dbus_ready;
    logic        O_mem_req;
    logic        O_mem_we;
    logic [31:0] O_mem_addr;
    logic [31:0] O_mem_data;
    logic [3:0]  O_mem_mask;
    logic        I_mem_ack;
    logic [31:0] I_mem_data;
    logic        O_bus_err;

    typedef struct packed {
        logic        dbus;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_ibus_rdy = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .I_ibus_req   (I_ibus_req),
        .I_ibus_addr  (I_ibus_addr),
        .O_ibus_data  (O_ibus_data),
        .O_ibus_ready (O_ibus_ready),
        .I_dbus_req   (I_dbus_req),
        .I_dbus_we    (I_dbus_we),
        .I_dbus_addr  (I_dbus_addr),
        .I_dbus_data  (I_dbus_data),
        .I_dbus_mask  (I_dbus_mask),
        .O_dbus_data  (O_dbus_data),
        .O_dbus_ready (O_dbus_ready),
        .O_mem_req    (O_mem_req),
        .O_mem_we     (O_mem_we),
        .O_mem_addr   (O_mem_addr),
        .O_mem_data   (O_mem_data),
        .O_mem_mask   (O_mem_mask),
        .I_mem_ack    (I_mem_ack),
        .I_mem_data   (I_mem_data),
        .O_bus_err    (O_bus_err)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_mem_req(input string tag);
        int n = 0;
        while (O_mem_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check(tag, O_mem_req, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {O_ibus_ready, O_dbus_ready, O_mem_req, O_mem_we, O_bus_err, O_mem_mask}, '0);
        check({tag, "_dat"}, {O_ibus_data, O_dbus_data, O_mem_addr, O_mem_data}, '0);
    endtask

    // Scoreboard: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && (O_ibus_ready === 1'b1 || O_dbus_ready === 1'b1)) begin
            exp_t e;
            if (O_ibus_ready === 1'b1) n_ibus_rdy++;
            check("single_ready", {O_ibus_ready, O_dbus_ready} == 2'b11, 1'b0);
            if (q.size() == 0) begin
                check("unexpected_ready", {O_ibus_ready, O_dbus_ready}, 2'b00);
            end else begin
                e = q.pop_front();
                check("rsp_owner", O_dbus_ready, e.dbus);
                check("rsp_data", e.dbus ? O_dbus_data : O_ibus_data, e.data);
                check("rsp_err", O_bus_err, e.err);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   cnt;
        int   rdy0;
        logic exp_dbus;
        rst = 1'b1;
        I_ibus_req = 0; I_ibus_addr = '0;
        I_dbus_req = 0; I_dbus_we = 0; I_dbus_addr = '0; I_dbus_data = '0; I_dbus_mask = '0;
        I_mem_ack = 0; I_mem_data = '0;
        tick(); tick();
        check_all_zero("reset_state");
        rst = 1'b0;
        tick();

        // 1: lone ibus read, zero-wait ack
        I_ibus_req = 1; I_ibus_addr = 32'h8000_0000;
        tick();
        check("t1_mem_req", O_mem_req, 1'b1);
        check("t1_mem_fields", {O_mem_we, O_mem_addr, O_mem_mask}, {1'b0, 32'h8000_0000, 4'h0});
        q.push_back('{dbus: 1'b0, data: 32'h0000_0013, err: 1'b0});
        I_mem_ack = 1; I_mem_data = 32'h0000_0013;
        tick();
        I_mem_ack = 0; I_ibus_req = 0;
        check("t1_ready", {O_ibus_ready, O_ibus_data, O_mem_req}, {1'b1, 32'h0000_0013, 1'b0});
        tick(); tick();

        // 2: lone dbus write, ack on the third BUSY cycle
        I_dbus_req = 1; I_dbus_we = 1; I_dbus_addr = 32'h8000_0100;
        I_dbus_data = 32'h1234_5678; I_dbus_mask = 4'b0011;
        tick();
        q.push_back('{dbus: 1'b1, data: 32'hCAFE_0000, err: 1'b0});
        for (int i = 0; i < 3; i++) begin
            check("t2_mem_stable", {O_mem_req, O_mem_we, O_mem_addr, O_mem_data, O_mem_mask, O_dbus_ready},
                  {1'b1, 1'b1, 32'h8000_0100, 32'h1234_5678, 4'b0011, 1'b0});
            if (i == 2) begin
                I_mem_ack = 1; I_mem_data = 32'hCAFE_0000;
            end
            tick();
        end
        I_mem_ack = 0; I_dbus_req = 0; I_dbus_we = 0;
        check("t2_ready", {O_dbus_ready, O_ibus_ready}, 2'b10);
        tick();
        check("t2_ready_pulse", O_dbus_ready, 1'b0);
        tick();

        // 3: both masters request continuously, four transactions from a fresh reset
        rst = 1; tick(); rst = 0;
        I_ibus_req = 1; I_ibus_addr = 32'h0000_1000;
        I_dbus_req = 1; I_dbus_we = 0; I_dbus_addr = 32'h0000_2000; I_dbus_mask = 4'hF;
        for (int n = 0; n < 4; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_dbus = (n % 2) == 0;
`else
            exp_dbus = 1'b1;
`endif
            wait_mem_req("t3_grant");
            check("t3_winner_addr", O_mem_addr, exp_dbus ? 32'h0000_2000 : 32'h0000_1000);
            q.push_back('{dbus: exp_dbus, data: 32'h100 + n, err: 1'b0});
            I_mem_ack = 1; I_mem_data = 32'h100 + n;
            tick();
            I_mem_ack = 0;
        end
        I_ibus_req = 0; I_dbus_req = 0;
        tick(); tick();

        // 4: dbus read never acked -> watchdog completion, late ack ignored
        I_dbus_req = 1; I_dbus_we = 0; I_dbus_addr = 32'h0000_4000;
        tick();
        q.push_back('{dbus: 1'b1, data: 32'hDEAD_BEEF, err: 1'b1});
        cnt = 0;
        while (O_mem_req === 1'b1 && cnt < 40) begin
            cnt++;
            tick();
        end
        I_dbus_req = 0;
        check("t4_busy_cycles", cnt, 16);
        check("t4_err_rsp", {O_dbus_ready, O_bus_err, O_dbus_data}, {1'b1, 1'b1, 32'hDEAD_BEEF});
        tick();
        I_mem_ack = 1; I_mem_data = 32'h1111_1111;
        tick();
        I_mem_ack = 0;
        tick();
        check("t4_late_ack", {O_dbus_ready, O_ibus_ready, O_mem_req, O_bus_err, O_dbus_data},
              {4'b0000, 32'hDEAD_BEEF});

        // 5: reset in BUSY discards the transaction
        I_ibus_req = 1; I_ibus_addr = 32'h0000_3000;
        tick();
        check("t5_busy", O_mem_req, 1'b1);
        rst = 1; I_ibus_req = 0;
        tick();
        check_all_zero("t5_after_rst");
        rst = 0; I_mem_ack = 1; I_mem_data = 32'h5555_5555;
        tick();
        I_mem_ack = 0;
        tick();
        check("t5_no_ready", {O_ibus_ready, O_dbus_ready, O_mem_req}, 3'b000);
        I_ibus_req = 1; I_ibus_addr = 32'h0000_3004;
        q.push_back('{dbus: 1'b0, data: 32'h0000_0077, err: 1'b0});
        tick();
        check("t5_fresh_req", {O_mem_req, O_mem_addr}, {1'b1, 32'h0000_3004});
        I_mem_ack = 1; I_mem_data = 32'h0000_0077;
        tick();
        I_mem_ack = 0; I_ibus_req = 0;
        check("t5_fresh_ready", {O_ibus_ready, O_ibus_data}, {1'b1, 32'h0000_0077});
        tick(); tick();

        // 6: ibus request held through RESP: no re-grant until IDLE
        rdy0 = n_ibus_rdy;
        I_ibus_req = 1; I_ibus_addr = 32'h0000_5000;
        q.push_back('{dbus: 1'b0, data: 32'h0000_00A1, err: 1'b0});
        q.push_back('{dbus: 1'b0, data: 32'h0000_00A2, err: 1'b0});
        tick();
        I_mem_ack = 1; I_mem_data = 32'h0000_00A1;
        tick();
        I_mem_ack = 0;
        check("t6_resp_no_req", {O_ibus_ready, O_mem_req}, 2'b10);
        tick();
        check("t6_idle_no_req", {O_ibus_ready, O_mem_req}, 2'b00);
        tick();
        check("t6_regrant", O_mem_req, 1'b1);
        I_mem_ack = 1; I_mem_data = 32'h0000_00A2;
        tick();
        I_mem_ack = 0; I_ibus_req = 0;
        tick(); tick(); tick();
        check("t6_ready_count", n_ibus_rdy - rdy0, 2);
        check("scoreboard_drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
